// File: rtl/log_arb_pkg.sv
// Shared types for the log2 engine arbiter: FSM state encoding and the
// {exponent, fraction} field widths of the engine result.
package log_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int EXP_W  = 3;
  localparam int FRAC_W = 5;

endpackage

// File: rtl/log_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with
// explicit wrap so non-power-of-2 requester counts work.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_vld
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_vld[wrap_add(ptr, i)]) grant = wrap_add(ptr, i);
    end
  end

  assign any_vld = |req_vld;

endmodule

// File: rtl/log_arbiter.sv
// Round-robin sequencer sharing one multi-cycle log2 engine among NUM_REQ
// requesters: accept, launch, wait for done or timeout, respond.
module log_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          eng_start_o,
  output logic [DATA_WIDTH-1:0]         eng_operand_o,
  input  logic                          eng_done_i,
  input  logic [DATA_WIDTH-1:0]         eng_result_i
);
  import log_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, grant_q, pick_idx;
  logic                    pick_any;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   operand_q, result_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   req_ops [NUM_REQ];
  logic                    cnt_last;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_ops
    assign req_ops[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_vld (req_valid_i),
    .ptr     (rr_ptr_q),
    .grant   (pick_idx),
    .any_vld (pick_any)
  );

  assign cnt_last = (cnt_q == CNT_W'(TIMEOUT-1));

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: if (pick_any) begin
        req_ready_o[pick_idx] = 1'b1;
        state_d               = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (eng_done_i || cnt_last) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Response and launch are pure decodes of registered state.
  always_comb begin
    rsp_valid_o = '0;
    if (state_q == ST_RESP) rsp_valid_o[grant_q] = 1'b1;
  end

  assign rsp_data_o    = (state_q == ST_RESP) ? result_q : '0;
  assign rsp_err_o     = (state_q == ST_RESP) & err_q;
  assign eng_start_o   = (state_q == ST_ISSUE);
  assign eng_operand_o = operand_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      operand_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (pick_any) begin
          grant_q   <= pick_idx;
          operand_q <= req_ops[pick_idx];
        end
        ST_ISSUE: cnt_q <= '0;
        // Done wins over a timeout landing in the same cycle.
        ST_WAIT: begin
          if (eng_done_i) begin
            result_q <= eng_result_i;
            err_q    <= 1'b0;
          end else if (cnt_last) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log_arbiter.sv
// Randomized bench for log_arbiter: transaction-level reference model with
// directed scenarios for latency, fairness, wrap, timeout and reset.
module tb_log_arbiter;
  import log_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 32;
  localparam int LAT_NEVER = -1;
  localparam int LAT_RAND  = -2;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic [NR-1:0]      req_valid_i;
  logic [NR*DW-1:0]   req_data_i;
  logic [NR-1:0]      req_ready_o, rsp_valid_o;
  logic [DW-1:0]      rsp_data_o, eng_operand_o, eng_result_i;
  logic               rsp_err_o, eng_start_o, eng_done_i;

  log_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk_i, .rstn_i, .req_valid_i, .req_data_i, .req_ready_o,
    .rsp_valid_o, .rsp_data_o, .rsp_err_o, .eng_start_o,
    .eng_operand_o, .eng_done_i, .eng_result_i
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0, cyc = 0, rsp_cnt = 0;
  int done_cyc = -1, eng_lat = 8, rate = 100;
  logic rnd = 1'b0;
  logic [DW-1:0] eng_op;
  // reference model state
  logic busy = 1'b0;
  int   m_ptr = 0, m_grant = 0, hs_cyc = 0, exp_rsp_cyc = -1;
  logic [DW-1:0] m_op, exp_data;
  logic exp_err;
  logic [NR-1:0] want = '0, waiting = '0, auto_req = '0, hs_rdy;
  logic [NR-1:0][DW-1:0] data = '0;
  int grant_log[$];
  int last_lat, last_grant;
  logic [DW-1:0] last_data;
  logic last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Engine result: exponent = msb position, fraction = the 5 bits below it.
  function automatic logic [DW-1:0] flog2(input logic [DW-1:0] x);
    int e;
    logic [15:0] t;
    if (x == 0) return '0;
    e = 0;
    for (int i = 0; i < DW; i++) if (x[i]) e = i;
    t = 16'(x) << (12 - e);
    return {EXP_W'(e), t[11 -: FRAC_W]};
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) if (v[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  function automatic int pick_lat();
    int r;
    if (eng_lat != LAT_RAND) return eng_lat;
    r = $urandom_range(0, 19);
    case (r)
      0: return LAT_NEVER;
      1: return 0;
      2: return TO;
      3: return TO + 1;
      4: return TO - 1;
      default: return $urandom_range(1, 12);
    endcase
  endfunction

  task automatic monitor();
    logic [NR-1:0] er, ev;
    int g;
    er = '0;
    g  = -1;
    if (!busy && req_valid_i != 0) begin
      g = pick(req_valid_i, m_ptr);
      er[g] = 1'b1;
    end
    chk("req_ready", 32'(req_ready_o), 32'(er));
    if (g >= 0) begin
      busy = 1'b1; m_grant = g; hs_cyc = cyc; exp_rsp_cyc = -1;
      m_op = data[g]; want[g] = 1'b0; waiting[g] = 1'b1;
      grant_log.push_back(g);
      hs_rdy = req_ready_o;
    end
    chk("eng_start", 32'(eng_start_o), 32'(busy && cyc == hs_cyc + 1));
    if (busy && cyc > hs_cyc) chk("eng_operand", 32'(eng_operand_o), 32'(m_op));
    if (busy && cyc == hs_cyc + 1) begin
      if (done_cyc >= hs_cyc + 2 && done_cyc <= hs_cyc + 1 + TO) begin
        exp_rsp_cyc = done_cyc + 1; exp_data = flog2(m_op); exp_err = 1'b0;
      end else begin
        exp_rsp_cyc = hs_cyc + 2 + TO; exp_data = '0; exp_err = 1'b1;
      end
    end
    ev = '0;
    if (busy && cyc == exp_rsp_cyc) ev[m_grant] = 1'b1;
    chk("rsp_valid", 32'(rsp_valid_o), 32'(ev));
    if (ev != 0) begin
      chk("rsp_data", 32'(rsp_data_o), 32'(exp_data));
      chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      last_lat = cyc - hs_cyc; last_data = rsp_data_o; last_err = rsp_err_o;
      last_grant = m_grant;
      busy = 1'b0; waiting[m_grant] = 1'b0; m_ptr = (m_grant + 1) % NR;
      rsp_cnt++;
    end
  endtask

  task automatic step();
    int l;
    @(posedge clk_i); cyc++;
    #1;
    if (eng_start_o) begin
      l = pick_lat();
      eng_op = eng_operand_o;
      done_cyc = (l < 0) ? -1 : cyc + l;
    end
    eng_done_i   = (cyc == done_cyc);
    eng_result_i = eng_done_i ? flog2(eng_op) : DW'($urandom);
    for (int k = 0; k < NR; k++) begin
      if (!want[k] && !waiting[k] && auto_req[k] && $urandom_range(0, 99) < rate) begin
        want[k] = 1'b1; data[k] = DW'($urandom);
      end else if (want[k] && rnd && $urandom_range(0, 31) == 0) begin
        want[k] = 1'b0;
      end
    end
    req_valid_i = want;
    req_data_i  = data;
    @(negedge clk_i);
    monitor();
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_ready"},   32'(req_ready_o),   0);
    chk({pfx, "_rsp_vld"}, 32'(rsp_valid_o),   0);
    chk({pfx, "_rsp_dat"}, 32'(rsp_data_o),    0);
    chk({pfx, "_rsp_err"}, 32'(rsp_err_o),     0);
    chk({pfx, "_start"},   32'(eng_start_o),   0);
    chk({pfx, "_operand"}, 32'(eng_operand_o), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); cyc++;
    #1;
    rstn_i = 1'b0;
    want = '0; waiting = '0; auto_req = '0; busy = 1'b0; m_ptr = 0;
    done_cyc = -1; eng_done_i = 1'b0; req_valid_i = '0;
    #1;
    chk_quiet("rst");
    @(posedge clk_i); cyc++;
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic run_rsp(input string tag, input int n, input int budget);
    int tgt, b;
    tgt = rsp_cnt + n;
    b = 0;
    while (rsp_cnt < tgt && b < budget) begin step(); b++; end
    chk(tag, 32'(rsp_cnt >= tgt), 1);
  endtask

  task automatic drain();
    int b;
    auto_req = '0; rnd = 1'b0; b = 0;
    while ((busy || want != 0) && b < 1000) begin step(); b++; end
    chk("drain", 32'(busy || want != 0), 0);
  endtask

  task automatic one_req(input int k, input logic [DW-1:0] d, input int lat, input string tag);
    eng_lat = lat; want[k] = 1'b1; data[k] = d;
    run_rsp(tag, 1, 200);
  endtask

  initial begin
    int m, rc, b;
    rstn_i = 1'b0; req_valid_i = '0; req_data_i = '0;
    eng_done_i = 1'b0; eng_result_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_quiet("init");
    rstn_i = 1'b1;

    // single request, requester 2, operand 8
    one_req(2, 8'd8, 8, "single_wait");
    chk("single_hs_ready", 32'(hs_rdy), 32'b0100);
    chk("single_grant", last_grant, 2);
    chk("single_lat", last_lat, 10);
    chk("single_data", 32'(last_data), 32'h60);
    chk("single_err", 32'(last_err), 0);

    // fairness from reset with all four requesting continuously
    pulse_reset();
    eng_lat = 8; rate = 100; auto_req = '1; want = '1;
    for (int k = 0; k < NR; k++) data[k] = DW'($urandom);
    m = grant_log.size();
    run_rsp("fair_wait", 5, 400);
    for (int i = 0; i < 5; i++) chk("fair_order", grant_log[m + i], i % NR);
    drain();

    // pointer wrap: 3 then {0,3} together
    m = grant_log.size();
    one_req(3, 8'h21, 3, "wrap_a");
    want[0] = 1'b1; data[0] = 8'h05; want[3] = 1'b1; data[3] = 8'hF0;
    run_rsp("wrap_b", 2, 200);
    chk("wrap_g0", grant_log[m], 3);
    chk("wrap_g1", grant_log[m + 1], 0);
    chk("wrap_g2", grant_log[m + 2], 3);

    // timeout, then a normal request
    one_req(1, 8'h77, LAT_NEVER, "to_wait");
    chk("to_lat", last_lat, TO + 2);
    chk("to_data", 32'(last_data), 0);
    chk("to_err", 32'(last_err), 1);
    one_req(0, 8'h80, 8, "after_to_wait");
    chk("after_to_data", 32'(last_data), 32'hE0);
    chk("after_to_err", 32'(last_err), 0);
    chk("after_to_lat", last_lat, 10);

    // done on the final WAIT cycle wins; one cycle later is ignored
    one_req(2, 8'h03, TO, "coinc_wait");
    chk("coinc_lat", last_lat, TO + 2);
    chk("coinc_err", 32'(last_err), 0);
    chk("coinc_data", 32'(last_data), 32'h30);
    one_req(2, 8'h03, TO + 1, "late_wait");
    chk("late_err", 32'(last_err), 1);
    chk("late_data", 32'(last_data), 0);

    // done during ISSUE is ignored
    one_req(1, 8'h40, 0, "issue_done_wait");
    chk("issue_done_err", 32'(last_err), 1);

    // reset while in WAIT: no response, next grant to requester 0
    eng_lat = LAT_NEVER; want[1] = 1'b1; data[1] = 8'h11;
    b = 0;
    while (!busy && b < 20) begin step(); b++; end
    chk("mid_hs", 32'(busy), 1);
    repeat (5) step();
    rc = rsp_cnt;
    pulse_reset();
    repeat (TO + 8) step();
    chk("mid_no_rsp", rsp_cnt, rc);
    eng_lat = 8; want = '1;
    for (int k = 0; k < NR; k++) data[k] = DW'($urandom);
    m = grant_log.size();
    run_rsp("mid_next_wait", 1, 100);
    chk("mid_next_grant", grant_log[m], 0);
    drain();

    // randomized traffic
    eng_lat = LAT_RAND; rate = 30; rnd = 1'b1; auto_req = '1;
    run_rsp("rand_wait", 300, 30000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
